// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 valid/ready demux: channel count, widths,
// slot state encoding and the select decode helper.
package demux_pkg;

    localparam int NUM_CH        = 4;
    localparam int SEL_W         = 2;
    localparam int DEFAULT_WIDTH = 32;
    localparam int COUNT_W       = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    function automatic logic [SEL_W-1:0] decode_ch(input logic s1, input logic s0);
        return {s1, s0};
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready buffer: a write may land in the same cycle the
// stored word drains, so the slot sustains one transfer per cycle.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_room,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready
);

    slot_state_t      r_state;
    slot_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // A write wins over a drain: drain+refill leaves the slot FULL with new data.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        if (wr_en) begin
            w_state_nxt = FULL;
            w_data_nxt  = wr_data;
        end else if (r_state == FULL && rd_ready) begin
            w_state_nxt = EMPTY;
        end
    end

    assign rd_valid = (r_state == FULL);
    assign rd_data  = r_data;
    assign wr_room  = (r_state == EMPTY) || rd_ready;

endmodule

// File: rtl/demux.sv
// 1-to-4 demux with a one-entry buffer per output channel.
// Optional per-channel drain counters are enabled with `define DEMUX_COUNT_EN.
module demux
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  din,
    input  logic              sel0,
    input  logic              sel1,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [WIDTH-1:0]  dout0,
    output logic [WIDTH-1:0]  dout1,
    output logic [WIDTH-1:0]  dout2,
    output logic [WIDTH-1:0]  dout3,
    output logic [NUM_CH-1:0] dout_valid,
    input  logic [NUM_CH-1:0] dout_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [NUM_CH*COUNT_W-1:0] drain_count
`endif
);

    logic [SEL_W-1:0]  w_ch;
    logic [NUM_CH-1:0] w_room;
    logic [NUM_CH-1:0] w_wr_en;
    logic [NUM_CH-1:0] w_valid;
    logic [WIDTH-1:0]  w_data [NUM_CH];

    assign w_ch      = decode_ch(sel1, sel0);
    assign din_ready = w_room[w_ch];

    always_comb begin
        w_wr_en = '0;
        if (din_valid && din_ready) begin
            w_wr_en[w_ch] = 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (w_wr_en[k]),
            .wr_data  (din),
            .wr_room  (w_room[k]),
            .rd_valid (w_valid[k]),
            .rd_data  (w_data[k]),
            .rd_ready (dout_ready[k])
        );
    end

    assign dout_valid = w_valid;
    assign dout0      = w_data[0];
    assign dout1      = w_data[1];
    assign dout2      = w_data[2];
    assign dout3      = w_data[3];

`ifdef DEMUX_COUNT_EN
    logic [NUM_CH-1:0]  w_drain;
    logic [COUNT_W-1:0] r_cnt [NUM_CH];

    assign w_drain = w_valid & dout_ready;

    // Counters wrap naturally at COUNT_W bits.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (!rst_n) begin
                r_cnt[k] <= '0;
            end else if (w_drain[k]) begin
                r_cnt[k] <= r_cnt[k] + COUNT_W'(1);
            end
        end
    end

    assign drain_count = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`endif

endmodule

// File: tb/tb_demux.sv
// Directed bench for demux: a per-channel scoreboard queue gets the word on each
// accepted write and is popped when that channel drains.
module tb_demux;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] din;
    logic         sel0;
    logic         sel1;
    logic         din_valid;
    logic         din_ready;
    logic [W-1:0] dout0, dout1, dout2, dout3;
    logic [3:0]   dout_valid;
    logic [3:0]   dout_ready;
`ifdef DEMUX_COUNT_EN
    logic [63:0]  drain_count;
`endif

    logic [W-1:0] dout_a [4];
    assign dout_a[0] = dout0;
    assign dout_a[1] = dout1;
    assign dout_a[2] = dout2;
    assign dout_a[3] = dout3;

    demux #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .sel0        (sel0),
        .sel1        (sel1),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dout0       (dout0),
        .dout1       (dout1),
        .dout2       (dout2),
        .dout3       (dout3),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready)
`ifdef DEMUX_COUNT_EN
        ,
        .drain_count (drain_count)
`endif
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] sb [4][$];
    logic [3:0]   m_full;
    logic [15:0]  m_cnt [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_full = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            sb[k].delete();
            m_cnt[k] = 16'd0;
        end
    endtask

    task automatic chk_count();
`ifdef DEMUX_COUNT_EN
        chk("drain_count", drain_count, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
`endif
    endtask

    // Drive one cycle from a negedge, predict the edge, check at the next negedge.
    task automatic tick(input logic [W-1:0] d, input int ch, input logic v, input logic [3:0] r);
        logic         exp_rdy;
        logic [W-1:0] exp_word;
        din        = d;
        {sel1, sel0} = 2'(ch);
        din_valid  = v;
        dout_ready = r;
        #1;
        exp_rdy = !m_full[ch] || r[ch];
        chk($sformatf("din_ready ch%0d", ch), 64'(din_ready), 64'(exp_rdy));
        for (int k = 0; k < 4; k++) begin
            if (m_full[k] && r[k]) begin
                exp_word = sb[k].pop_front();
                chk($sformatf("drain_data ch%0d", k), 64'(dout_a[k]), 64'(exp_word));
                m_full[k] = 1'b0;
                m_cnt[k]  = m_cnt[k] + 16'd1;
            end
        end
        if (v && exp_rdy) begin
            sb[ch].push_back(d);
            m_full[ch] = 1'b1;
        end
        @(negedge clk);
        chk("dout_valid", 64'(dout_valid), 64'(m_full));
        for (int k = 0; k < 4; k++) begin
            if (m_full[k]) begin
                chk($sformatf("dout_word ch%0d", k), 64'(dout_a[k]), 64'(sb[k][0]));
            end
        end
        chk_count();
    endtask

    // One reset edge with busy inputs; nothing may transfer through it.
    task automatic do_reset();
        rst_n      = 1'b0;
        din        = 32'hFFFF_FFFF;
        {sel1, sel0} = 2'b11;
        din_valid  = 1'b1;
        dout_ready = 4'b1111;
        @(negedge clk);
        rst_n      = 1'b1;
        din_valid  = 1'b0;
        dout_ready = 4'b0000;
        #1;
        model_clear();
        chk("rst dout_valid", 64'(dout_valid), 64'h0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst dout%0d", k), 64'(dout_a[k]), 64'h0);
        end
        chk("rst din_ready", 64'(din_ready), 64'h1);
        chk_count();
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = '0;
        sel0       = 1'b0;
        sel1       = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 4'b0000;
        model_clear();
        @(negedge clk);
        do_reset();

        // Single write to channel 2; other channels stay at reset value.
        tick(32'hDEADBEEF, 2, 1'b1, 4'b0000);
        chk("idle dout0", 64'(dout0), 64'h0);
        chk("idle dout1", 64'(dout1), 64'h0);
        chk("idle dout3", 64'(dout3), 64'h0);

        // Stalled slot 2 refuses a second write but does not block channel 1.
        tick(32'h0000_0099, 2, 1'b1, 4'b0000);
        tick(32'h0000_0001, 1, 1'b1, 4'b0000);
        chk("after ch1 write", 64'(dout_valid), 64'h6);

        // Drain and refill slot 3 in the same cycle.
        tick(32'h0000_00AA, 3, 1'b1, 4'b0000);
        tick(32'h0000_0055, 3, 1'b1, 4'b1000);
        chk("refill dout3", 64'(dout3), 64'h55);

        // Invalid input with toggling select must not change any slot.
        for (int i = 0; i < 4; i++) begin
            tick($urandom, i, 1'b0, 4'b0000);
        end
        tick(32'h0, 0, 1'b0, 4'b1111);

        // Back-to-back streaming through channel 0.
        for (int i = 0; i < 10; i++) begin
            tick(32'h1000 + 32'(i), 0, 1'b1, 4'b0001);
        end
        tick(32'h0, 0, 1'b0, 4'b0001);
        chk("ch0 drains", 64'(m_cnt[0]), 64'd10);

        // Reset with all four slots occupied.
        for (int i = 0; i < 4; i++) begin
            tick(32'hC0DE_0000 + 32'(i), i, 1'b1, 4'b0000);
        end
        do_reset();

`ifdef DEMUX_COUNT_EN
        for (int i = 0; i < 65537; i++) begin
            tick($urandom, 1, 1'b1, 4'b0010);
        end
        tick(32'h0, 1, 1'b0, 4'b0010);
        chk("ch1 wrap", 64'(drain_count[31:16]), 64'd1);
`else
        for (int i = 0; i < 20; i++) begin
            tick($urandom, 1, 1'b1, 4'b0010);
        end
        tick(32'h0, 1, 1'b0, 4'b0010);
`endif
        chk("final dout_valid", 64'(dout_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/demux.md
DEMUX -- requirements
Module: demux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width of input and every output channel.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 The block SHALL have port din, input, WIDTH, write data to be routed.
REQ-005 The block SHALL have port sel0, input, 1, channel select LSB.
REQ-006 The block SHALL have port sel1, input, 1, channel select MSB.
REQ-007 The block SHALL have port din_valid, input, 1, din/sel0/sel1 valid.
REQ-008 The block SHALL have port din_ready, output, 1, block accepts din this cycle.
REQ-009 The block SHALL have ports dout0, dout1, dout2 and dout3, output, WIDTH each, channel data.
REQ-010 The block SHALL have port dout_valid, output, 4, per-channel data valid (bit k = channel k).
REQ-011 The block SHALL have port dout_ready, input, 4, per-channel consumer ready.

Function
REQ-012 The block SHALL decode the channel as k = {sel1,sel0}: 00->0, 01->1, 10->2, 11->3.
REQ-013 The block SHALL hold one one-entry buffer per channel, each with state EMPTY or FULL.
REQ-014 The block SHALL drive din_ready = (slot k EMPTY) OR (slot k FULL AND dout_ready[k]), purely combinational from current state and inputs.
REQ-015 The block SHALL accept a transfer when din_valid AND din_ready, writing din into slot k and setting it FULL at the next edge; latency 1 cycle.
REQ-016 The block SHALL drive dout_valid[k] high exactly when slot k is FULL, with doutk equal to the stored word.
REQ-017 The block SHALL complete a drain when dout_valid[k] AND dout_ready[k]; slot k returns to EMPTY unless refilled in the same cycle.
REQ-018 The block SHALL support a simultaneous drain and refill of the same slot: the slot stays FULL with the new word, giving one transfer per cycle per channel.
REQ-019 The block SHALL hold doutk and dout_valid[k] stable while dout_valid[k] is high and dout_ready[k] is low.
REQ-020 The block SHALL let slots drain independently; a FULL stalled slot SHALL NOT block writes to other channels.
REQ-021 The block SHALL ignore din, sel0 and sel1 when din_valid is low; they SHALL NOT change any state.
REQ-022 The block SHALL NOT alter non-selected slots on an accepted write.

Reset
REQ-023 The block SHALL, while rst_n is low at a rising edge, set all slots EMPTY, dout_valid = 4'b0000 and dout0..dout3 = 0.
REQ-024 The block SHALL discard buffered data on a reset asserted mid-operation, with no transfer completing in that cycle.
REQ-025 The block SHALL drive din_ready high in the first cycle after reset release.

Configuration
REQ-026 The block SHALL use macro DEMUX_COUNT_EN; when defined, it SHALL add output port drain_count, 64 bits, holding four 16-bit counters (bits [16k+15:16k] = channel k).
REQ-027 The block SHALL, when DEMUX_COUNT_EN is defined, increment counter k by 1 on each drain of channel k, wrapping 16'hFFFF->0, and clear all counters on reset.
REQ-028 The block SHALL, when DEMUX_COUNT_EN is undefined, have no drain_count port and no counter logic; all other behaviour is identical.

Structure
REQ-029 The block SHALL take from shared package demux_pkg: NUM_CH = 4, default WIDTH = 32, slot-state enum {EMPTY, FULL} and COUNT_W = 16.
REQ-030 The block SHALL instantiate sub-module demux_slot four times; each demux_slot is a one-entry valid/ready buffer with write-enable, data in, and drain handshake.

Verification
REQ-031 Verification SHALL cover: after reset, din=32'hDEADBEEF, sel={1,0}, din_valid=1, dout_ready=4'b0000 -> next cycle dout_valid=4'b0100, dout2=32'hDEADBEEF, others 0.
REQ-032 Verification SHALL cover: slot 2 FULL with dout_ready[2]=0, second write to channel 2 -> din_ready=0; simultaneous write of 32'h1 to channel 1 -> accepted, dout_valid=4'b0110.
REQ-033 Verification SHALL cover: slot 3 FULL, dout_ready[3]=1, write 32'h55 to channel 3 in the same cycle -> din_ready=1, slot stays FULL, dout3=32'h55 next cycle.
REQ-034 Verification SHALL cover: 10 back-to-back writes to channel 0 with dout_ready[0]=1 -> 10 drains on consecutive cycles, data in order, drain_count[15:0]=10 when DEMUX_COUNT_EN is defined.
REQ-035 Verification SHALL cover: all four slots FULL, rst_n=0 for one edge -> dout_valid=4'b0000, all doutk=0, din_ready=1, counters 0.
REQ-036 Verification SHALL cover: 65537 drains on channel 1 with DEMUX_COUNT_EN defined -> drain_count[31:16]=1 (wrap); din_valid=0 with toggling sel -> no state change.
